// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// The WIDTH-bit operands are cut into STAGES equal slices. Each slice is a
// BLOCK-grouped lookahead adder followed by a register, so the carry crosses
// one slice per clock. Operand bits are skewed forward, and finished low sums
// are deskewed, so all bits of one transaction leave the pipe together.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned S  = WIDTH / STAGES;
  localparam int unsigned NG = S / BLOCK;

  if (STAGES == 0 || BLOCK == 0 || (WIDTH % (STAGES * BLOCK)) != 0) begin : g_bad_params
    $error("pipelined_cla_adder: WIDTH must be a multiple of STAGES*BLOCK");
  end

  // Sum-of-products lookahead carry into position base+n from a carry cin
  // entering position base; every term is formed directly from p/g, so no
  // carry ripples from one position to the next.
  function automatic logic f_carry(input logic [S-1:0] p, input logic [S-1:0] g,
                                   input logic cin, input int unsigned base,
                                   input int unsigned n);
    logic c;
    logic t;
    c = cin;
    for (int unsigned m = 0; m < n; m++) c = c & p[base+m];
    for (int unsigned m = 0; m < n; m++) begin
      t = g[base+m];
      for (int unsigned q = m + 1; q < n; q++) t = t & p[base+q];
      c = c | t;
    end
    return c;
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_a_eff;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  assign w_a_eff   = a;
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = carry_in ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits this stage still carries: its own slice plus all higher ones.
    localparam int unsigned IW = (STAGES - k) * S;

    logic [IW-1:0]        w_ain;
    logic [IW-1:0]        w_bin;
    logic                 w_ci;
    logic                 w_vin;
    logic [S-1:0]         w_p;
    logic [S-1:0]         w_g;
    logic [S-1:0]         w_c;
    logic [S-1:0]         w_s;
    logic [NG-1:0]        w_gp;
    logic [NG-1:0]        w_gg;
    logic [NG:0]          w_gc;
    logic [(k+1)*S-1:0]   w_sum_nxt;

    logic                 r_v;
    logic [(k+1)*S-1:0]   r_sum;
    logic                 r_c;

    if (k == 0) begin : g_src
      assign w_ain     = w_a_eff;
      assign w_bin     = w_b_eff;
      assign w_ci      = w_cin_eff;
      assign w_vin     = in_valid;
      assign w_sum_nxt = w_s;
    end else begin : g_src
      assign w_ain     = g_stage[k-1].g_fwd.r_a;
      assign w_bin     = g_stage[k-1].g_fwd.r_b;
      assign w_ci      = g_stage[k-1].r_c;
      assign w_vin     = g_stage[k-1].r_v;
      assign w_sum_nxt = {w_s, g_stage[k-1].r_sum};
    end

    // Slice adder: group P/G, group carries from group P/G, bit carries from group carry-in.
    always_comb begin
      w_p  = w_ain[S-1:0] ^ w_bin[S-1:0];
      w_g  = w_ain[S-1:0] & w_bin[S-1:0];
      w_gp = '0;
      w_gg = '0;
      w_gc = '0;
      w_c  = '0;
      for (int unsigned j = 0; j < NG; j++) begin
        w_gp[j] = &w_p[j*BLOCK +: BLOCK];
        w_gg[j] = f_carry(w_p, w_g, 1'b0, j * BLOCK, BLOCK);
      end
      for (int unsigned j = 0; j <= NG; j++)
        w_gc[j] = f_carry(S'(w_gp), S'(w_gg), w_ci, 32'd0, j);
      for (int unsigned j = 0; j < NG; j++)
        for (int unsigned i = 0; i < BLOCK; i++)
          w_c[j*BLOCK+i] = f_carry(w_p, w_g, w_gc[j], j * BLOCK, i);
      w_s = w_p ^ w_c;
    end

    // Stage valid shifts on every advance; data loads only for a valid entry.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v   <= 1'b0;
        r_sum <= '0;
        r_c   <= 1'b0;
      end else if (w_adv) begin
        r_v <= w_vin;
        if (w_vin) begin
          r_sum <= w_sum_nxt;
          r_c   <= w_gc[NG];
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IW-S-1:0] r_a;
      logic [IW-S-1:0] r_b;

      // Skew registers: pass the not-yet-added upper operand bits to the next stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_vin) begin
          r_a <= w_ain[IW-1:S];
          r_b <= w_bin[IW-1:S];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic r_cmsb;

      // Carry into the MSB, kept alongside carry_out for the overflow flag.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_cmsb <= 1'b0;
        else if (w_adv && w_vin)   r_cmsb <= w_c[S-1];
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign sum       = g_stage[STAGES-1].r_sum;
  assign carry_out = g_stage[STAGES-1].r_c;
  assign overflow  = g_stage[STAGES-1].g_last.r_cmsb ^ g_stage[STAGES-1].r_c;
  assign w_adv     = !out_valid | out_ready;
  assign in_ready  = w_adv;

endmodule
